vip_frame_sequencer: RTL
========================

Name: vip_frame_sequencer

Overview:
Frame-level controller between the pixel input FIFO (show-ahead read side) and the VIP processing pipeline. On a start command it latches frame width/height, pops exactly width*height pixels from the FIFO, and presents them on a registered valid/ready stream tagged with SOF/EOL/EOF markers and x/y coordinates. Supports single-shot or continuous frames, with stop honoured only at frame boundaries.

Parameters:
DWIDTH, 24, pixel data width (RGB888)
DIM_W, 11, width of the width/height/coordinate fields
FCNT_W, 16, width of the completed-frame counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle start command; sampled only in IDLE
stop  in  1  one-cycle request to halt continuous mode at the next frame end
cfg_width  in  DIM_W  pixels per line; latched at accepted start
cfg_height  in  DIM_W  lines per frame; latched at accepted start
cfg_continuous  in  1  1 = auto-restart after each frame; latched at start
fifo_empty  in  1  FIFO empty flag
fifo_q  in  DWIDTH  FIFO head data (show-ahead, valid while !fifo_empty)
fifo_rdreq  out  1  pop FIFO head this cycle
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts pixel when valid&ready
out_data  out  DWIDTH  pixel data
out_sof  out  1  first pixel of frame (x=0,y=0)
out_eol  out  1  last pixel of line
out_eof  out  1  last pixel of frame
out_x  out  DIM_W  column of current output pixel
out_y  out  DIM_W  row of current output pixel
busy  out  1  high in RUN or DRAIN
frame_done  out  1  one-cycle pulse when EOF pixel is accepted downstream
cfg_error  out  1  one-cycle pulse when start is rejected
frame_cnt  out  FCNT_W  completed frames since reset, wraps

Behaviour:
- Reset: state=IDLE; fifo_rdreq, out_valid, out_sof/eol/eof, busy, frame_done, cfg_error = 0; out_data, out_x, out_y, frame_cnt, internal counters = 0. Reset mid-frame discards everything; the FIFO is not flushed.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 with cfg_width!=0 and cfg_height!=0 -> latch cfg, clear rd_x/rd_y, -> RUN next cycle. Start with either dimension zero -> cfg_error pulse next cycle, stay IDLE. Start outside IDLE is ignored.
- RUN: load = !fifo_empty && (!out_valid || out_ready). fifo_rdreq = load (combinational). On load: out_data<=fifo_q, out_valid<=1, out_x<=rd_x, out_y<=rd_y, sof/eol/eof decoded from rd_x/rd_y against latched dims; rd_x increments, wraps to 0 at width-1 with rd_y++. Loading the last pixel (rd_x=W-1, rd_y=H-1) -> DRAIN. No pop ever occurs outside RUN.
- Output register: out_valid clears when accepted without a new load; data/flags held stable while valid && !ready.
- Throughput: 1 pixel/cycle sustained; latency FIFO pop -> out_valid = 1 cycle.
- DRAIN: waits for EOF acceptance; then frame_done pulse and frame_cnt++ in the following cycle. Next state: RUN (counters cleared, same cfg) if continuous and no stop pending, else IDLE. stop is captured into a sticky flag at any cycle in RUN/DRAIN and cleared on entering IDLE.
- Single-shot: stop is a no-op.
- Width=1: every pixel has eol. Height=1: eof on line 0. 1x1: sof, eol, eof all on the same pixel.
- fifo_empty during RUN simply stalls; no timeout.
- frame_cnt wraps 2^FCNT_W-1 -> 0.
- busy is a registered decode of state != IDLE.

Decomposition:
- Shared package vip_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_DRAIN), default DWIDTH/DIM_W.
- One natural sub-module: vip_xy_counter (width/height-wrapping x/y counter with first/last-column/row decodes), reusable by downstream blocks.

Test Plan:
- 4x3 frame, FIFO always non-empty, out_ready=1 -> 12 consecutive pixels; sof on #0, eol on #3/#7/#11, eof on #11; frame_done pulse 1 cycle after; frame_cnt=1; exactly 12 rdreq.
- Same 4x3 frame, out_ready toggled 1-0-1-0 and fifo_empty randomly asserted -> data order preserved, output held stable while stalled, no pop while empty, still exactly 12 pops.
- start with cfg_width=0, height=5 -> cfg_error pulse, busy stays 0, no rdreq.
- Continuous 2x2, stop pulsed during frame 2 -> exactly 2 frames output, frame_cnt=2, return to IDLE, no 9th pop.
- 1x1 frame -> single pixel with sof=eol=eof=1, out_x=out_y=0.
- Reset asserted after 5 of 12 pixels -> all outputs 0 immediately, IDLE; new start produces a complete frame beginning with sof.

Source files
------------

// File: rtl/vip_pkg.sv
// rtl/vip_pkg.sv - shared state encoding and default widths for the VIP frame path
package vip_pkg;

  localparam int DWIDTH_DEF = 24;
  localparam int DIM_W_DEF  = 11;
  localparam int FCNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vip_xy_counter.sv
// rtl/vip_xy_counter.sv - raster x/y counter wrapping at width/height with edge decodes
module vip_xy_counter #(
  parameter int DIM_W = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] x,
  output logic [DIM_W-1:0] y,
  output logic             first_col,
  output logic             last_col,
  output logic             first_row,
  output logic             last_row
);

  logic [DIM_W-1:0] x_q, x_d;
  logic [DIM_W-1:0] y_q, y_d;

  always_comb begin
    first_col = (x_q == '0);
    last_col  = (x_q == width - DIM_W'(1));
    first_row = (y_q == '0);
    last_row  = (y_q == height - DIM_W'(1));
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      // The final pixel wraps both axes so a restarted frame begins at the origin.
      if (last_col) begin
        x_d = '0;
        y_d = last_row ? '0 : y_q + DIM_W'(1);
      end else begin
        x_d = x_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/vip_frame_sequencer.sv
// rtl/vip_frame_sequencer.sv - pops width*height pixels from a show-ahead FIFO and
// streams them out registered, tagged with SOF/EOL/EOF and x/y coordinates
module vip_frame_sequencer
  import vip_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int FCNT_W = FCNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic              cfg_continuous,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic [DIM_W-1:0]  out_x,
  output logic [DIM_W-1:0]  out_y,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_error,
  output logic [FCNT_W-1:0] frame_cnt
);

  seq_state_t state_q, state_d;

  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic              cont_q, cont_d;
  logic              stop_pend_q, stop_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_sof_q, out_sof_d;
  logic              out_eol_q, out_eol_d;
  logic              out_eof_q, out_eof_d;
  logic [DIM_W-1:0]  out_x_q, out_x_d;
  logic [DIM_W-1:0]  out_y_q, out_y_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              cfg_error_q, cfg_error_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic             cfg_ok, accept, stop_seen;
  logic             load, cnt_clear, frame_end;
  logic [DIM_W-1:0] rd_x, rd_y;
  logic             first_col, last_col, first_row, last_row;

  assign cfg_ok    = (cfg_width != '0) && (cfg_height != '0);
  assign accept    = out_valid_q && out_ready;
  assign stop_seen = stop_pend_q || stop;

  vip_xy_counter #(
    .DIM_W(DIM_W)
  ) u_rd_xy (
    .clock     (clock),
    .reset     (reset),
    .clear     (cnt_clear),
    .inc       (load),
    .width     (width_q),
    .height    (height_q),
    .x         (rd_x),
    .y         (rd_y),
    .first_col (first_col),
    .last_col  (last_col),
    .first_row (first_row),
    .last_row  (last_row)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && cfg_ok) state_d = ST_RUN;
      ST_RUN:   if (load && last_col && last_row) state_d = ST_DRAIN;
      ST_DRAIN: if (accept) state_d = (cont_q && !stop_seen) ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    cnt_clear = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      ST_IDLE:  cnt_clear = start && cfg_ok;
      ST_RUN:   load = !fifo_empty && (!out_valid_q || out_ready);
      ST_DRAIN: begin
        frame_end = accept;
        cnt_clear = accept;
      end
      default: ;
    endcase
  end

  assign fifo_rdreq = load;

  always_comb begin
    width_d  = width_q;
    height_d = height_q;
    cont_d   = cont_q;
    if (state_q == ST_IDLE && start && cfg_ok) begin
      width_d  = cfg_width;
      height_d = cfg_height;
      cont_d   = cfg_continuous;
    end

    // Stop is only honoured at a frame boundary, so it is held until IDLE is reached.
    stop_pend_d = stop_pend_q;
    if (state_d == ST_IDLE)      stop_pend_d = 1'b0;
    else if (state_q != ST_IDLE) stop_pend_d = stop_pend_q || stop;

    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_q;
      out_sof_d   = first_col && first_row;
      out_eol_d   = last_col;
      out_eof_d   = last_col && last_row;
      out_x_d     = rd_x;
      out_y_d     = rd_y;
    end

    busy_d       = (state_d != ST_IDLE);
    frame_done_d = frame_end;
    frame_cnt_d  = frame_end ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;
    cfg_error_d  = (state_q == ST_IDLE) && start && !cfg_ok;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      width_q      <= '0;
      height_q     <= '0;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_error_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      width_q      <= width_d;
      height_q     <= height_d;
      cont_q       <= cont_d;
      stop_pend_q  <= stop_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sof_q    <= out_sof_d;
      out_eol_q    <= out_eol_d;
      out_eof_q    <= out_eof_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cfg_error_q  <= cfg_error_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign out_eof    = out_eof_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cfg_error  = cfg_error_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
